// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and sequencer state encoding shared by the ALU sequencer, control decoder and ALU
package alu_pkg;

  localparam logic [3:0] FN_NOP = 4'b0000;
  localparam logic [3:0] FN_ADD = 4'b0001;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_lat_counter.sv
// rtl/alu_lat_counter.sv - loadable down-counter with zero flag tracking remaining EXEC cycles
module alu_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU op sequencer (IDLE->EXEC->DONE) with valid/ready request and response
// Optional feature macro ALU_SEQ_DIVZ_EN: DIV by zero answers immediately with all-ones data and rsp_err.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  seq_state_t        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              busy_q, busy_d;

  logic              funct_legal;
  logic [CNT_W-1:0]  lat_val;
  logic              cnt_load, cnt_dec, cnt_zero;

  // Counter holds remaining EXEC cycles minus one, so zero marks the capture cycle.
  always_comb begin
    funct_legal = 1'b1;
    lat_val     = '0;
    case (req_funct)
      FN_ADD, FN_SUB: lat_val = '0;
      FN_MUL:         lat_val = CNT_W'(MUL_LAT - 1);
      FN_DIV:         lat_val = CNT_W'(DIV_LAT - 1);
      default:        funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    busy_d      = busy_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (!funct_legal) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end
`ifdef ALU_SEQ_DIVZ_EN
          else if ((req_funct == FN_DIV) && (req_b == '0)) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {DATA_W{1'b1}};
            rsp_err_d   = 1'b1;
          end
`endif
          else begin
            state_d    = S_EXEC;
            alu_ctrl_d = req_funct;
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            cnt_load   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cnt_zero) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_result;
          rsp_err_d   = 1'b0;
          alu_ctrl_d  = FN_NOP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        alu_ctrl_d  = FN_NOP;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_ctrl_q  <= FN_NOP;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      busy_q      <= busy_d;
    end
  end

  alu_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(lat_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign busy      = busy_q;

endmodule
